// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared constants, FSM encoding and payload-slice helpers for the regfile write-port arbiter.
package regfile_arb_pkg;

    localparam int RF_AW    = 5;
    localparam int RF_DW    = 32;
    localparam int RF_BW    = 4;
    localparam int MAX_NREQ = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_e;

    // Buses are zero-extended to MAX_NREQ lanes so one helper serves any NREQ.
    function automatic logic [RF_AW-1:0] addr_slice(input logic [MAX_NREQ*RF_AW-1:0] bus,
                                                    input logic [2:0] i);
        return bus[i*RF_AW +: RF_AW];
    endfunction

    function automatic logic [RF_DW-1:0] data_slice(input logic [MAX_NREQ*RF_DW-1:0] bus,
                                                    input logic [2:0] i);
        return bus[i*RF_DW +: RF_DW];
    endfunction

    function automatic logic [RF_BW-1:0] wen_slice(input logic [MAX_NREQ*RF_BW-1:0] bus,
                                                   input logic [2:0] i);
        return bus[i*RF_BW +: RF_BW];
    endfunction

endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// Requester-side req/gnt handshake bundle: requesters are the master, the arbiter the slave.
interface regfile_wport_arbiter_if
    import regfile_arb_pkg::*;
#(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]       req;
    logic [NREQ*RF_AW-1:0] req_waddr;
    logic [NREQ*RF_DW-1:0] req_wdata;
    logic [NREQ*RF_BW-1:0] req_wen;
    logic [NREQ-1:0]       gnt;

    modport master (output req, req_waddr, req_wdata, req_wen, input gnt);
    modport slave  (input req, req_waddr, req_wdata, req_wen, output gnt);
endinterface

// File: rtl/regfile_wport_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: rotate req by ptr, pick the lowest set bit, rotate back.
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt
);
    logic [NREQ-1:0]   rot;
    logic [NREQ-1:0]   rot_gnt;
    logic [2*NREQ-1:0] gnt_dbl;
    logic              found;

    always_comb begin
        rot     = NREQ'({req, req} >> ptr);
        rot_gnt = '0;
        found   = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (rot[j] && !found) begin
                rot_gnt[j] = 1'b1;
                found      = 1'b1;
            end
        end
        // Un-rotate: bits shifted past the top wrap back via the upper half.
        gnt_dbl = {{NREQ{1'b0}}, rot_gnt} << ptr;
        gnt     = gnt_dbl[NREQ-1:0] | gnt_dbl[2*NREQ-1:NREQ];
    end
endmodule

// File: rtl/regfile_wport_arbiter.sv
// Round-robin arbiter for the single regfile write port, registered output stage, stall counter.
// Optional post-reset clear sweep of r1..r31 when RF_INIT_SWEEP_EN is defined.
module regfile_wport_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    regfile_wport_arbiter_if.slave rq,
    output logic [RF_BW-1:0]     rf_wen,
    output logic [RF_AW-1:0]     rf_waddr,
    output logic [RF_DW-1:0]     rf_wdata,
    output logic                 busy,
    output logic [CNT_W-1:0]     stall_cnt
);
    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0]  gnt_raw;
    logic             arb_en;
    logic [PW-1:0]    sel;
    logic             multi_req;
    logic [MAX_NREQ*RF_AW-1:0] wa_ext;
    logic [MAX_NREQ*RF_DW-1:0] wd_ext;
    logic [MAX_NREQ*RF_BW-1:0] we_ext;
    logic [RF_AW-1:0] sel_addr;
    logic [RF_DW-1:0] sel_data;
    logic [RF_BW-1:0] sel_wen;

    logic [RF_BW-1:0] rf_wen_q, rf_wen_d;
    logic [RF_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [RF_DW-1:0] rf_wdata_q, rf_wdata_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

`ifdef RF_INIT_SWEEP_EN
    state_e           state_q, state_d;
    logic [RF_AW-1:0] sweep_addr_q, sweep_addr_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_INIT;
            sweep_addr_q <= RF_AW'(1);
        end else begin
            state_q      <= state_d;
            sweep_addr_q <= sweep_addr_d;
        end
    end

    assign busy   = (state_q == ST_INIT);
    assign arb_en = resetn & ~busy;
`else
    assign busy   = 1'b0;
    assign arb_en = resetn;
`endif

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req (rq.req),
        .ptr (rr_ptr_q),
        .gnt (gnt_raw)
    );

    assign rq.gnt    = arb_en ? gnt_raw : '0;
    assign multi_req = |(rq.req & (rq.req - 1'b1));

    always_comb begin
        sel    = '0;
        wa_ext = '0;
        wd_ext = '0;
        we_ext = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt_raw[i]) sel = PW'(i);
        wa_ext[NREQ*RF_AW-1:0] = rq.req_waddr;
        wd_ext[NREQ*RF_DW-1:0] = rq.req_wdata;
        we_ext[NREQ*RF_BW-1:0] = rq.req_wen;
        sel_addr = addr_slice(wa_ext, 3'(sel));
        sel_data = data_slice(wd_ext, 3'(sel));
        sel_wen  = wen_slice(we_ext, 3'(sel));
    end

    always_comb begin
        rf_wen_d    = '0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        rr_ptr_d    = rr_ptr_q;
        stall_cnt_d = stall_cnt_q;
`ifdef RF_INIT_SWEEP_EN
        state_d      = state_q;
        sweep_addr_d = sweep_addr_q;
        if (state_q == ST_INIT) begin
            rf_wen_d     = '1;
            rf_waddr_d   = sweep_addr_q;
            rf_wdata_d   = '0;
            sweep_addr_d = sweep_addr_q + 1'b1;
            if (sweep_addr_q == '1) state_d = ST_ARB;
        end else
`endif
        begin
            if (|gnt_raw) begin
                // Null writes complete the handshake but never touch r0 or write nothing.
                rf_wen_d   = (sel_addr != '0) ? sel_wen : '0;
                rf_waddr_d = sel_addr;
                rf_wdata_d = sel_data;
                rr_ptr_d   = (sel == PW'(NREQ-1)) ? '0 : sel + 1'b1;
            end
            if (multi_req && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rf_wen_q    <= '0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            rr_ptr_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            rf_wen_q    <= rf_wen_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            rr_ptr_q    <= rr_ptr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign rf_wen    = rf_wen_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign stall_cnt = stall_cnt_q;
endmodule
